// File: rtl/spi9_panel_init_seq.sv
// ROM-driven panel init sequencer: pulses lcd_rst, then streams 9-bit SPI
// frames (D/C + 8 data bits) and delays fetched from an external synchronous ROM.
module spi9_panel_init_seq #(
  parameter int CLK_DIV         = 2,
  parameter int ROM_AW          = 8,
  parameter int RST_LOW_CYCLES  = 10000,
  parameter int RST_WAIT_CYCLES = 20000,
  parameter int DELAY_UNIT      = 100000,
  parameter int AUTO_START      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  output logic              cs,
  output logic              sclk,
  output logic              sout,
  output logic              lcd_rst
);

  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int RST_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int BIG_MAX = (DLY_MAX > RST_MAX) ? DLY_MAX : RST_MAX;
  localparam int CNT_MAX = (BIG_MAX > 2 * CLK_DIV) ? BIG_MAX : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, FETCH, SHIFT, GAP, DELAY, DONE
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [4:0]        half_reg;
  logic [7:0]        sr_reg;
  logic              fetch_wait_reg;
  logic              last_reg;
  logic              first_reg;
  logic              cs_reg, sclk_reg, sout_reg, lcd_rst_reg, busy_reg, done_reg;
  logic [ROM_AW-1:0] rom_addr_reg;

  logic [1:0] op;
  logic [7:0] val;
  assign op  = rom_data[9:8];
  assign val = rom_data[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      half_reg       <= '0;
      sr_reg         <= '0;
      fetch_wait_reg <= 1'b0;
      last_reg       <= 1'b0;
      first_reg      <= 1'b1;
      cs_reg         <= 1'b1;
      sclk_reg       <= 1'b0;
      sout_reg       <= 1'b0;
      lcd_rst_reg    <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      rom_addr_reg   <= '0;
    end else begin
      first_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          // The first edge after reset release only honours AUTO_START, never start.
          if (first_reg ? (AUTO_START != 0) : start) begin
            state_reg    <= RST_LOW;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            lcd_rst_reg  <= 1'b0;
            rom_addr_reg <= '0;
            last_reg     <= 1'b0;
            cnt_reg      <= CNT_W'(RST_LOW_CYCLES - 1);
          end
        end
        RST_LOW: begin
          if (cnt_reg == '0) begin
            lcd_rst_reg <= 1'b1;
            state_reg   <= RST_WAIT;
            cnt_reg     <= CNT_W'(RST_WAIT_CYCLES - 1);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RST_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg      <= FETCH;
            fetch_wait_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        FETCH: begin
          if (!fetch_wait_reg) begin
            fetch_wait_reg <= 1'b1;
          end else begin
            fetch_wait_reg <= 1'b0;
            if (op == 2'b11) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              // The top address is the last entry: flag it instead of wrapping.
              if (&rom_addr_reg) last_reg <= 1'b1;
              else rom_addr_reg <= rom_addr_reg + 1'b1;
              if (!op[1]) begin
                state_reg <= SHIFT;
                cs_reg    <= 1'b0;
                sout_reg  <= op[0];
                sr_reg    <= val;
                half_reg  <= '0;
                cnt_reg   <= CNT_W'(CLK_DIV - 1);
              end else if (val == 8'd0) begin
                if (&rom_addr_reg) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                end
              end else begin
                state_reg <= DELAY;
                cnt_reg   <= CNT_W'(val) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
              end
            end
          end
        end
        SHIFT: begin
          if (cnt_reg == '0) begin
            cnt_reg  <= CNT_W'(CLK_DIV - 1);
            half_reg <= half_reg + 1'b1;
            if (!half_reg[0]) begin
              sclk_reg <= 1'b1;
            end else begin
              sclk_reg <= 1'b0;
              if (half_reg == 5'd17) begin
                state_reg <= GAP;
                cs_reg    <= 1'b1;
                sout_reg  <= 1'b0;
                cnt_reg   <= CNT_W'(2 * CLK_DIV - 1);
              end else begin
                sout_reg <= sr_reg[7];
                sr_reg   <= {sr_reg[6:0], 1'b0};
              end
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        GAP, DELAY: begin
          if (cnt_reg == '0) begin
            if (last_reg) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg      <= FETCH;
              fetch_wait_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rom_addr = rom_addr_reg;
  assign cs       = cs_reg;
  assign sclk     = sclk_reg;
  assign sout     = sout_reg;
  assign lcd_rst  = lcd_rst_reg;

endmodule
